// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the RTC bus-cycle engine between the hora/fecha/crono write groups
// and the periodic read burst, sequencing each group as single-register req/ack transactions.
module rtc_bus_scheduler #(
  parameter int REFRESH_DIV = 10000,
  parameter int TIMEOUT     = 255,
  parameter int ADDR_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_hora,
  input  logic              req_fecha,
  input  logic              req_crono,
  output logic              gnt_hora,
  output logic              gnt_fecha,
  output logic              gnt_crono,
  output logic              read_done,
  output logic              err,
  output logic              busy,
  output logic              lock,
  output logic [3:0]        idx,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_e;
  typedef enum logic [1:0] {G_HORA, G_FECHA, G_CRONO, G_READ} grp_e;

  state_e            state_q, state_d;
  grp_e              grp_q, grp_d, win;
  logic [3:0]        idx_q, idx_d, last_idx;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [CW-1:0]     cnt_q;
  logic              pend_q, pend_clr, wrap, any_wr, done_ok;
  logic              lock_q, lock_d, abort_q, abort_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        ent_addr;
  logic              ent_we;

  // Refresh counter: a wrap while a read is already pending is simply absorbed.
  assign wrap = (cnt_q == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
      pend_q <= (pend_q & ~pend_clr) | wrap;
    end
  end

  assign any_wr   = req_hora | req_fecha | req_crono;
  assign win      = req_hora ? G_HORA : req_fecha ? G_FECHA : req_crono ? G_CRONO : G_READ;
  assign last_idx = (grp_q == G_READ) ? 4'd9 : 4'd3;

  // Register list entry for (grp_q, idx_q); write groups end with the 0xF1 commit.
  always_comb begin
    ent_we   = 1'b1;
    ent_addr = 8'h00;
    unique case (grp_q)
      G_HORA:  ent_addr = (idx_q == 4'd3) ? 8'hF1 : 8'h21 + {4'd0, idx_q};
      G_FECHA: ent_addr = (idx_q == 4'd3) ? 8'hF1 : 8'h24 + {4'd0, idx_q};
      G_CRONO: ent_addr = (idx_q == 4'd3) ? 8'hF1 : 8'h41 + {4'd0, idx_q};
      G_READ: begin
        ent_we = (idx_q == 4'd0);
        if (idx_q == 4'd0)      ent_addr = 8'hF2;
        else if (idx_q <= 4'd6) ent_addr = 8'h20 + {4'd0, idx_q};
        else                    ent_addr = 8'h3A + {4'd0, idx_q};
      end
      default: ent_addr = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    lock_d   = lock_q;
    abort_d  = abort_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    pend_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // lock rises with ARB so it drops for exactly one IDLE cycle between write groups
        if (any_wr | pend_q) begin
          state_d = S_ARB;
          lock_d  = any_wr;
        end
      end
      S_ARB: begin
        idx_d   = '0;
        abort_d = 1'b0;
        if (any_wr | pend_q) begin
          grp_d    = win;
          lock_d   = (win != G_READ);
          pend_clr = (win == G_READ);
          state_d  = S_ISSUE;
        end else begin
          lock_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        we_d    = ent_we;
        addr_d  = ADDR_W'(ent_addr);
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          state_d = S_NEXT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_NEXT: begin
        if (idx_q == last_idx) state_d = S_DONE;
        else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        lock_d  = 1'b0;
        idx_d   = '0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grp_q   <= G_HORA;
      idx_q   <= '0;
      tmo_q   <= '0;
      lock_q  <= 1'b0;
      abort_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      lock_q  <= lock_d;
      abort_q <= abort_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  assign done_ok   = (state_q == S_DONE) & ~abort_q;
  assign gnt_hora  = done_ok & (grp_q == G_HORA);
  assign gnt_fecha = done_ok & (grp_q == G_FECHA);
  assign gnt_crono = done_ok & (grp_q == G_CRONO);
  assign read_done = done_ok & (grp_q == G_READ);
  assign err       = (state_q == S_DONE) & abort_q;
  assign busy      = (state_q != S_IDLE);
  assign lock      = lock_q;
  assign idx       = idx_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Randomized bench for rtc_bus_scheduler: a group-timeline model predicts every cycle's outputs
// from the request levels, refresh period and the ack latency the bench picks per transaction.
module tb_rtc_bus_scheduler;

  localparam int DIV = 300;
  localparam int TMO = 20;

  logic       clock = 1'b0, reset = 1'b0;
  logic       req_hora = 1'b0, req_fecha = 1'b0, req_crono = 1'b0, bus_ack = 1'b0;
  logic       gnt_hora, gnt_fecha, gnt_crono, read_done, err, busy, lock, bus_req, bus_we;
  logic [3:0] idx;
  logic [7:0] bus_addr;

  rtc_bus_scheduler #(.REFRESH_DIV(DIV), .TIMEOUT(TMO), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_hora(req_hora), .req_fecha(req_fecha), .req_crono(req_crono),
    .gnt_hora(gnt_hora), .gnt_fecha(gnt_fecha), .gnt_crono(gnt_crono),
    .read_done(read_done), .err(err), .busy(busy), .lock(lock), .idx(idx),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_ack(bus_ack)
  );

  always #5 clock = ~clock;

  int         nchk = 0, nerr = 0;
  int         t = 0, tot = 0;
  logic [2:0] m_req = 3'b000;   // held requests: bit0 hora, bit1 fecha, bit2 crono
  bit         m_pend = 1'b0;    // read burst owed by the refresh period
  logic [2:0] inj_req = 3'b000;
  int         lat_fix = -1, req_pct = 0;
  bit         no_ack_once = 1'b0, rst_hook = 1'b0, fecha_hook = 1'b0;
  int         c_gh = 0, c_gf = 0, c_gc = 0, c_rd = 0, c_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, act, exp);
    end
  endtask

  task automatic drive_req();
    req_hora  = m_req[0];
    req_fecha = m_req[1];
    req_crono = m_req[2];
  endtask

  task automatic step();
    @(negedge clock);
    t++;
    tot++;
    bus_ack = 1'b0;
    if (t % DIV == 0) m_pend = 1'b1;
    if (gnt_hora)  c_gh++;
    if (gnt_fecha) c_gf++;
    if (gnt_crono) c_gc++;
    if (read_done) c_rd++;
    if (err)       c_err++;
    if (tot > 60000) begin
      $display("FAIL watchdog t=%0d", t);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic expo(input string tag, input bit bsy, input bit lk, input int ix,
                      input bit rq, input logic [4:0] pl);
    chk(tag, {20'd0, busy, lock, idx, bus_req, gnt_hora, gnt_fecha, gnt_crono, read_done, err},
             {20'd0, bsy, lk, 4'(ix), rq, pl});
  endtask

  function automatic logic [7:0] eaddr(input int g, input int j);
    logic [7:0] rd [10];
    rd = '{8'hF2, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    if (g == 3) return rd[j];
    if (j == 3) return 8'hF1;
    return (g == 0) ? 8'(8'h21 + j) : (g == 1) ? 8'(8'h24 + j) : 8'(8'h41 + j);
  endfunction

  // Called in the ARB cycle; walks the whole group timeline.
  task automatic group();
    int g, n, lat, jl;
    bit lk, ab;
    g  = m_req[0] ? 0 : m_req[1] ? 1 : m_req[2] ? 2 : 3;
    if (g == 3) m_pend = 1'b0;
    n  = (g == 3) ? 10 : 4;
    lk = (g != 3);
    ab = 1'b0;
    jl = n - 1;
    expo("arb", 1, lk, 0, 0, 5'd0);
    for (int j = 0; j < n; j++) begin
      step();
      expo("issue", 1, lk, j, 0, 5'd0);
      if (no_ack_once) begin lat = TMO; no_ack_once = 1'b0; end
      else if (lat_fix >= 0) lat = lat_fix;
      else lat = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, TMO - 1);
      for (int w = 0; w < TMO; w++) begin
        step();
        expo("wait", 1, lk, j, 1, 5'd0);
        chk("addr", {24'd0, bus_addr}, {24'd0, eaddr(g, j)});
        chk("we", {31'd0, bus_we}, {31'd0, (g != 3 || j == 0)});
        if (rst_hook && g == 2 && j == 2) begin
          #2 reset = 1'b0;
          #1;
          chk("rst_async", {11'd0, busy, lock, idx, bus_req, bus_we, bus_addr,
                            gnt_hora, gnt_fecha, gnt_crono, read_done, err}, 32'd0);
          rst_hook = 1'b0;
          m_req = 3'b000;
          drive_req();
          m_pend = 1'b0;
          repeat (2) @(negedge clock);
          reset = 1'b1;
          t = 0;
          return;
        end
        if (fecha_hook && g == 3 && j == 4 && w == 0) begin
          m_req[1] = 1'b1;
          drive_req();
          fecha_hook = 1'b0;
        end
        if (req_pct > 0 && $urandom_range(0, 99) < req_pct) begin
          m_req[$urandom_range(0, 2)] = 1'b1;
          drive_req();
        end
        if (w == lat) begin
          bus_ack = 1'b1;
          break;
        end
      end
      if (lat >= TMO) begin
        ab = 1'b1;
        jl = j;
        break;
      end
      step();
      expo("next", 1, lk, j, 0, 5'd0);
    end
    step();
    expo("done", 1, lk, jl, 0, ab ? 5'b00001 :
         (g == 0) ? 5'b10000 : (g == 1) ? 5'b01000 : (g == 2) ? 5'b00100 : 5'b00010);
    if (!ab && g < 3) begin
      m_req[g] = 1'b0;
      drive_req();
    end
  endtask

  task automatic run(input int ncyc, input bit spur);
    for (int k = 0; k < ncyc; k++) begin
      step();
      expo("idle", 0, 0, 0, 0, 5'd0);
      if (spur && $urandom_range(0, 5) == 0) bus_ack = 1'b1;
      if (inj_req != 3'b000) begin
        m_req   = m_req | inj_req;
        inj_req = 3'b000;
        drive_req();
      end else if (req_pct > 0 && $urandom_range(0, 99) < req_pct) begin
        m_req[$urandom_range(0, 2)] = 1'b1;
        drive_req();
      end
      if (m_req != 3'b000 || m_pend) begin
        step();
        group();
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst", {11'd0, busy, lock, idx, bus_req, bus_we, bus_addr,
                gnt_hora, gnt_fecha, gnt_crono, read_done, err}, 32'd0);
    reset = 1'b1;
    t = 0;

    // single automatic read burst, ack one cycle after bus_req
    lat_fix = 1;
    run(DIV + 40, 1'b1);
    chk("burst_cnt", c_rd, 1);

    // hora and crono together: hora first, then crono
    inj_req = 3'b101;
    run(60, 1'b1);
    chk("gnt_hora_cnt", c_gh, 1);
    chk("gnt_crono_cnt", c_gc, 1);

    // fecha raised mid read burst waits for the burst to finish
    fecha_hook = 1'b1;
    run(DIV, 1'b1);
    chk("gnt_fecha_cnt", c_gf, 1);
    chk("burst_cnt2", c_rd, 2);

    // no ack: timeout, err, then hora retried and granted
    no_ack_once = 1'b1;
    inj_req = 3'b001;
    run(60, 1'b1);
    chk("err_cnt", c_err, 1);
    chk("gnt_hora_retry", c_gh, 2);

    // async reset during crono WAIT at idx 2; next burst is timed from release
    rst_hook = 1'b1;
    inj_req = 3'b100;
    run(DIV + 60, 1'b1);
    chk("crono_aborted_by_reset", c_gc, 1);

    // random traffic
    lat_fix = -1;
    req_pct = 6;
    for (int r = 0; r < 15; r++) begin
      if ($urandom_range(0, 3) == 0) no_ack_once = 1'b1;
      run(40, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
